// File: rtl/pong_pkg.sv
// Shared encodings for the pong match logic: FSM states, winner codes and
// the BCD score width, plus the two-digit BCD increment used by the counters.
package pong_pkg;

  localparam int BCD_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SERVE = 2'b01;
  localparam logic [1:0] ST_PLAY  = 2'b10;
  localparam logic [1:0] ST_OVER  = 2'b11;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  // Ones digit wraps 9 -> 0 and carries into tens; 99 is never incremented.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = v[7:4];
    ones = v[3:0];
    if (ones == 4'd9) begin
      return {tens + 4'd1, 4'd0};
    end
    return {tens, ones + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_counter_2d.sv
// Two-digit BCD score counter with a 7-bit binary shadow that tracks the same
// count, so win detection can use a plain binary compare.
module bcd_counter_2d
  import pong_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [BCD_W-1:0] value,
  output logic [6:0]       shadow
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value  <= '0;
      shadow <= '0;
    end else if (clear) begin
      value  <= '0;
      shadow <= '0;
    end else if (inc) begin
      value  <= bcd_inc(value);
      shadow <= shadow + 7'd1;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Match controller: turns the ball stage's point pulses into BCD scores and
// runs the idle / serve pause / play / game over sequence that gates the ball.
module score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_FRAMES = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             start,
  input  logic             point_1,
  input  logic             point_2,
  output logic [BCD_W-1:0] score_1,
  output logic [BCD_W-1:0] score_2,
  output logic             ball_hold,
  output logic             game_over,
  output logic [1:0]       winner,
  output logic [1:0]       state
);

  localparam logic [6:0] WIN_BIN    = 7'(WIN_SCORE);
  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);

  logic             start_q_reg;
  logic             start_rise;
  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [7:0]       cnt_reg;
  logic [7:0]       cnt_next;
  logic [1:0]       winner_reg;
  logic [1:0]       winner_next;
  logic             clear_scores;
  logic [1:0]       inc_vec;
  logic [BCD_W-1:0] score_vec  [2];
  logic [6:0]       shadow_vec [2];

  assign start_rise = start & ~start_q_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_player
      bcd_counter_2d u_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear_scores),
        .inc    (inc_vec[gi]),
        .value  (score_vec[gi]),
        .shadow (shadow_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    winner_next  = winner_reg;
    clear_scores = 1'b0;
    inc_vec      = 2'b00;
    case (state_reg)
      ST_IDLE: begin
        if (start_rise) begin
          state_next = ST_SERVE;
          cnt_next   = SERVE_LOAD;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          cnt_next = cnt_reg - 8'd1;
          if (cnt_reg == 8'd1) begin
            state_next = ST_PLAY;
          end
        end
      end
      ST_PLAY: begin
        // A simultaneous pair of pulses is a glitch upstream: re-serve, no score.
        if (point_1 && point_2) begin
          state_next = ST_SERVE;
          cnt_next   = SERVE_LOAD;
        end else if (point_1) begin
          inc_vec[0] = 1'b1;
          if (shadow_vec[0] + 7'd1 == WIN_BIN) begin
            state_next  = ST_OVER;
            winner_next = WIN_P1;
          end else begin
            state_next = ST_SERVE;
            cnt_next   = SERVE_LOAD;
          end
        end else if (point_2) begin
          inc_vec[1] = 1'b1;
          if (shadow_vec[1] + 7'd1 == WIN_BIN) begin
            state_next  = ST_OVER;
            winner_next = WIN_P2;
          end else begin
            state_next = ST_SERVE;
            cnt_next   = SERVE_LOAD;
          end
        end
      end
      ST_OVER: begin
        if (start_rise) begin
          clear_scores = 1'b1;
          winner_next  = WIN_NONE;
          state_next   = ST_SERVE;
          cnt_next     = SERVE_LOAD;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q_reg <= 1'b0;
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      winner_reg  <= WIN_NONE;
    end else begin
      start_q_reg <= start;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      winner_reg  <= winner_next;
    end
  end

  assign score_1   = score_vec[0];
  assign score_2   = score_vec[1];
  assign state     = state_reg;
  assign winner    = winner_reg;
  assign ball_hold = (state_reg != ST_PLAY);
  assign game_over = (state_reg == ST_OVER);

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: two instances (win at 3 and at 11, serve pause of 3
// ticks) share one stimulus stream and are checked against an integer model.
module tb_score_keeper;

  localparam int SF = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       point_1 = 1'b0;
  logic       point_2 = 1'b0;
  logic [7:0] a_s1, a_s2, b_s1, b_s2;
  logic       a_hold, b_hold, a_go, b_go;
  logic [1:0] a_w, b_w, a_st, b_st;

  always #5 clk = ~clk;

  score_keeper #(.WIN_SCORE(3), .SERVE_FRAMES(SF)) dut_a (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .point_1(point_1), .point_2(point_2), .score_1(a_s1), .score_2(a_s2),
    .ball_hold(a_hold), .game_over(a_go), .winner(a_w), .state(a_st)
  );

  score_keeper #(.WIN_SCORE(11), .SERVE_FRAMES(SF)) dut_b (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .point_1(point_1), .point_2(point_2), .score_1(b_s1), .score_2(b_s2),
    .ball_hold(b_hold), .game_over(b_go), .winner(b_w), .state(b_st)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer scores and a phase number per instance.
  int win_score [2] = '{3, 11};
  int m_phase [2];
  int m_cnt [2];
  int m_s1 [2];
  int m_s2 [2];
  int m_w [2];
  int m_start_prev;
  logic st_lvl = 1'b0;

  function automatic logic [7:0] to_bcd(input int s);
    return 8'((s / 10) * 16 + (s % 10));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_cnt[k] = 0; m_s1[k] = 0; m_s2[k] = 0; m_w[k] = 0;
    end
    m_start_prev = 0;
  endtask

  task automatic model_edge();
    bit rise;
    rise = (start == 1'b1) && (m_start_prev == 0);
    m_start_prev = int'(start);
    for (int k = 0; k < 2; k++) begin
      if (m_phase[k] == 0) begin
        if (rise) begin m_phase[k] = 1; m_cnt[k] = SF; end
      end else if (m_phase[k] == 1) begin
        if (frame_tick) begin
          m_cnt[k]--;
          if (m_cnt[k] == 0) m_phase[k] = 2;
        end
      end else if (m_phase[k] == 2) begin
        if (point_1 && point_2) begin
          m_phase[k] = 1; m_cnt[k] = SF;
        end else if (point_1 || point_2) begin
          if (point_1) m_s1[k]++; else m_s2[k]++;
          if ((point_1 ? m_s1[k] : m_s2[k]) == win_score[k]) begin
            m_phase[k] = 3; m_w[k] = point_1 ? 1 : 2;
          end else begin
            m_phase[k] = 1; m_cnt[k] = SF;
          end
        end
      end else if (rise) begin
        m_s1[k] = 0; m_s2[k] = 0; m_w[k] = 0; m_phase[k] = 1; m_cnt[k] = SF;
      end
    end
  endtask

  task automatic compare_one(input int k, input logic [7:0] s1, input logic [7:0] s2,
                             input logic hold, input logic go, input logic [1:0] w,
                             input logic [1:0] st);
    check($sformatf("score_1[%0d]", k), s1, to_bcd(m_s1[k]));
    check($sformatf("score_2[%0d]", k), s2, to_bcd(m_s2[k]));
    check($sformatf("state[%0d]", k), {6'd0, st}, 8'(m_phase[k]));
    check($sformatf("winner[%0d]", k), {6'd0, w}, 8'(m_w[k]));
    check($sformatf("ball_hold[%0d]", k), {7'd0, hold}, {7'd0, m_phase[k] != 2});
    check($sformatf("game_over[%0d]", k), {7'd0, go}, {7'd0, m_phase[k] == 3});
  endtask

  task automatic compare_all();
    compare_one(0, a_s1, a_s2, a_hold, a_go, a_w, a_st);
    compare_one(1, b_s1, b_s2, b_hold, b_go, b_w, b_st);
  endtask

  task automatic cyc(input logic ft, input logic st, input logic p1, input logic p2);
    frame_tick = ft; start = st; point_1 = p1; point_2 = p2;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    $display("cyc t=%0t ft=%0b st=%0b p=%0b%0b | A %h:%h s%0d | B %h:%h s%0d",
             $time, ft, st, p1, p2, a_s1, a_s2, a_st, b_s1, b_s2, b_st);
  endtask

  task automatic tick();
    cyc(1'b1, st_lvl, 1'b0, 1'b0);
  endtask

  // Reset is raised between clock edges so the checks prove it acts asynchronously.
  task automatic do_reset();
    @(negedge clk);
    frame_tick = 1'b0; start = 1'b0; point_1 = 1'b0; point_2 = 1'b0; st_lvl = 1'b0;
    #1 reset = 1'b1;
    #1 model_reset();
    compare_all();
    check("async_reset_state_a", {6'd0, a_st}, 8'h00);
    check("async_reset_hold_b", {7'd0, b_hold}, 8'h01);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Serve pause of exactly SF ticks.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("serve_entry_state", {6'd0, a_st}, 8'h01);
    check("serve_entry_hold", {7'd0, a_hold}, 8'h01);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tick(); cyc(1'b0, 1'b0, 1'b0, 1'b0); tick();
    check("serve_after_2_ticks", {6'd0, a_st}, 8'h01);
    tick();
    check("play_after_3_ticks", {6'd0, a_st}, 8'h02);
    check("play_hold", {7'd0, a_hold}, 8'h00);

    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("p1_first_point", a_s1, 8'h01);
    check("p1_reserve_state", {6'd0, a_st}, 8'h01);
    check("p1_reserve_hold", {7'd0, a_hold}, 8'h01);
    tick(); tick();
    check("reserve_2_ticks", {6'd0, b_st}, 8'h01);
    tick();
    check("reserve_3_ticks", {6'd0, b_st}, 8'h02);

    // Ten points to player 2: instance A wins at 3, B crosses 9 -> 10 in BCD.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      if (i == 2) begin
        check("win_state", {6'd0, a_st}, 8'h03);
        check("win_game_over", {7'd0, a_go}, 8'h01);
        check("win_winner", {6'd0, a_w}, 8'h02);
        check("win_score_2", a_s2, 8'h03);
      end
      if (i == 8) check("b_score_9", b_s2, 8'h09);
      tick(); tick(); tick();
    end
    check("over_hold_score_2", a_s2, 8'h03);
    check("over_hold_score_1", a_s1, 8'h01);
    check("over_hold_winner", {6'd0, a_w}, 8'h02);
    check("bcd_carry_10", b_s2, 8'h10);

    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("both_points_state", {6'd0, b_st}, 8'h01);
    check("both_points_s1", b_s1, 8'h01);
    check("both_points_s2", b_s2, 8'h10);

    // Start held 5 cycles: A clears once, B in SERVE ignores start and points.
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("restart_state", {6'd0, a_st}, 8'h01);
    check("restart_s1", a_s1, 8'h00);
    check("restart_s2", a_s2, 8'h00);
    check("restart_winner", {6'd0, a_w}, 8'h00);
    check("serve_ignore_s1", b_s1, 8'h01);
    check("serve_ignore_s2", b_s2, 8'h10);
    st_lvl = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) st_lvl = ~st_lvl;
      cyc(logic'($urandom_range(0, 2) == 0), st_lvl,
          logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    // Reset in the middle of a serve pause.
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("mid_serve_state", {6'd0, a_st}, 8'h01);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
